audio_fir_dither: RTL and testbench
===================================

// Module: audio_fir_dither
// PURPOSE
//  Parametrised successor to the mono byte-stream DSP stage: offset-binary UART audio
//  bytes in, signed dithered PCM (I2S/DAC width) out. Interleaved NUM_CH channels,
//  programmable TAPS-tap FIR on one time-shared MAC, saturation, LFSR dither, and
//  valid/ready handshakes on both sides. Sits between the UART byte receiver and I2S TX.
// PARAMETERS
//  IN_W      8   input sample width (offset-binary)
//  OUT_W     24  output sample width (signed two's complement), OUT_W > IN_W
//  NUM_CH    2   interleaved channels, >=1
//  TAPS      4   FIR taps per channel, >=1
//  COEF_W    16  signed coefficient width
//  COEF_FRAC 14  coefficient fraction bits (unity = 2^COEF_FRAC)
//  DITHER_W  8   dither LSBs added at output; 0 = dither off
// PORTS
//  clk       in  1                 system clock
//  rst_n     in  1                 async active-low reset
//  flush     in  1                 sync clear of history/state
//  in_data   in  IN_W              offset-binary sample
//  in_valid  in  1                 in_data valid
//  in_ready  out 1                 block can accept
//  coef_we   in  1                 coefficient write strobe
//  coef_addr in  clog2(TAPS)       tap index
//  coef_data in  COEF_W            signed coefficient
//  coef_ack  out 1                 1-cycle pulse: write taken
//  out_data  out OUT_W             signed filtered sample
//  out_ch    out clog2(NUM_CH)     channel of out_data (width 1 if NUM_CH=1)
//  out_valid out 1                 out_data valid
//  out_ready in  1                 sink accepts
// BEHAVIOUR
//  Reset (async): out_data=0, out_ch=0, out_valid=0, in_ready=1, coef_ack=0, history=0,
//   channel counter=0, LFSR=16'hACE1, coef[0]=2^COEF_FRAC, other coefs=0, state IDLE.
//  Input: IN_W-bit value converted to signed by inverting its MSB (0x80 -> 0, 0xFF -> +127).
//  FSM: IDLE -> MAC -> ROUND -> OUT -> IDLE.
//   IDLE: in_ready=1. On in_valid: shift the sample into history[ch], latch ch, go MAC.
//   MAC: TAPS cycles, acc += coef[k]*hist[ch][k], k=0 (newest)..TAPS-1.
//    ACC_W = IN_W+COEF_W+clog2(TAPS)+1.
//   ROUND: y = (acc <<< (OUT_W-IN_W)) >>> COEF_FRAC (arithmetic shift, floor).
//    y += sign-extended dither; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//    Register out_data and out_ch; go to OUT.
//   OUT: out_valid=1; out_data and out_ch hold stable until out_ready; on out_ready go IDLE
//    and advance the channel counter (wraps NUM_CH-1 -> 0).
//  Latency: accept at cycle 0, out_valid at cycle TAPS+2. Throughput is 1 sample per TAPS+3
//   cycles when out_ready=1.
//  in_ready=0 in every state except IDLE. No combinational path from in_valid to in_ready.
//  Dither: 16-bit Fibonacci LFSR, feedback bits 15^13^12^10, steps every clk.
//   d = LFSR[DITHER_W-1:0] as signed DITHER_W-bit value, sampled in ROUND.
//  Coefficients: a write is taken only in IDLE with no same-cycle input accept; then
//   coef_ack pulses. Otherwise the write is dropped and coef_ack=0, so a sample never sees
//   a mid-MAC change.
//  flush (sync) beats everything, including in_valid and coef_we in the same cycle. It
//   aborts MAC/ROUND/OUT, drops out_valid the next cycle, and zeroes history, the channel
//   counter and the noise-shaping state. The LFSR and coefficients are kept. State -> IDLE.
//  rst_n asserted mid-operation: immediate return to reset values; an in-flight sample is
//   lost.
// CONFIGURATION
//  NOISE_SHAPE_EN defined: first-order error feedback per channel.
//   d_eff = d - e[ch], and e[ch] <= d after each ROUND; d_eff is DITHER_W+1 bits and is
//   sign-extended before the add. e[] resets and flushes to 0.
//  NOISE_SHAPE_EN undefined: d_eff = d (flat dither) and no e[] storage.
//  Either build: DITHER_W=0 removes dither entirely.
// TESTING (bench: defaults, DITHER_W=0 unless stated)
//  1 Reset coefs, ch0 0xFF, ch1 0x00 -> out 24'h7F0000 ch0, then 24'h800000 ch1, each at
//    TAPS+2=6 cycles after accept.
//  2 All four coefs = 16384. ch0 step 0xC0 x4 (ch1 = 0x80):
//    ch0 -> 0x400000, 0x7FFFFF (sat), 0x7FFFFF, 0x7FFFFF; ch1 -> 0 each time.
//  3 out_ready held low 10 cycles in OUT -> out_data/out_ch stable, in_ready=0 throughout,
//    no input taken.
//  4 coef_we during MAC -> coef_ack=0 and the coef is unchanged. Same write in IDLE ->
//    coef_ack=1 for 1 cycle.
//  5 flush in cycle 2 of MAC -> no out_valid. Next 0xFF -> ch0 out 24'h7F0000 with clean
//    history. Repeat with rst_n instead of flush.
//  6 DITHER_W=8, input 0x80 stream, both builds -> |out| <= 128 (256 with NOISE_SHAPE_EN);
//    LFSR sequence matches the reference model.

Source files
------------

// File: rtl/audio_fir_dither_if.sv
// Stream, coefficient and output handshake bundle for audio_fir_dither.
// slave = the filter block, master = the driving/consuming environment.
`timescale 1ns/1ps
interface audio_fir_dither_if #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 24,
  parameter int COEF_W = 16,
  parameter int AW     = 2,
  parameter int CW     = 1
) ();
  logic [IN_W-1:0]   in_data;
  logic              in_valid;
  logic              in_ready;
  logic              coef_we;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_data;
  logic              coef_ack;
  logic [OUT_W-1:0]  out_data;
  logic [CW-1:0]     out_ch;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data, in_valid, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, coef_ack, out_data, out_ch, out_valid
  );

  modport slave (
    input  in_data, in_valid, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, coef_ack, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/audio_fir_dither.sv
// Multichannel offset-binary to signed PCM stage: time-shared FIR MAC, saturation, LFSR dither.
// Optional build macro NOISE_SHAPE_EN adds first-order per-channel dither error feedback.
`timescale 1ns/1ps
module audio_fir_dither #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 24,
  parameter int NUM_CH    = 2,
  parameter int TAPS      = 4,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int DITHER_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  audio_fir_dither_if.slave bus
);

  localparam int AW    = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = IN_W + COEF_W + $clog2(TAPS) + 1;
  localparam int P_W   = IN_W + COEF_W;
  localparam int SH    = OUT_W - IN_W;
  localparam int Y_W   = ACC_W + SH + 1;
  localparam int DE_W  = (DITHER_W > 0) ? DITHER_W + 1 : 1;

  localparam logic [AW-1:0]            LAST_K   = AW'(TAPS - 1);
  localparam logic [CW-1:0]            LAST_CH  = CW'(NUM_CH - 1);
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << COEF_FRAC);

  typedef enum logic [1:0] {IDLE, MAC, ROUND, OUT} state_t;

  state_t state, state_nxt;

  logic signed [IN_W-1:0]   hist [NUM_CH][TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            k;
  logic [CW-1:0]            ch_cnt;
  logic [CW-1:0]            cur_ch;
  logic [15:0]              lfsr;
  logic                     lfsr_fb;

  logic signed [IN_W-1:0]   sample_in;
  logic signed [P_W-1:0]    prod;
  logic signed [Y_W-1:0]    scaled;
  logic signed [Y_W-1:0]    y_sum;
  logic signed [DE_W-1:0]   d_eff;
  logic [OUT_W-1:0]         y_sat;

  // Offset-binary to two's complement is just an MSB flip.
  assign sample_in = {~bus.in_data[IN_W-1], bus.in_data[IN_W-2:0]};

  assign prod    = P_W'(coef[k]) * P_W'(hist[cur_ch][k]);
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == OUT);

  generate
    if (DITHER_W > 0) begin : g_dither
      logic signed [DITHER_W-1:0] d;
      assign d = lfsr[DITHER_W-1:0];
`ifdef NOISE_SHAPE_EN
      logic signed [DITHER_W-1:0] err [NUM_CH];

      assign d_eff = {d[DITHER_W-1], d} - {err[cur_ch][DITHER_W-1], err[cur_ch]};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned c = 0; c < NUM_CH; c++) err[c] <= '0;
        end else if (flush) begin
          for (int unsigned c = 0; c < NUM_CH; c++) err[c] <= '0;
        end else if (state == ROUND) begin
          err[cur_ch] <= d;
        end
      end
`else
      assign d_eff = {d[DITHER_W-1], d};
`endif
    end else begin : g_no_dither
      assign d_eff = '0;
    end
  endgenerate

  // Scale to output width first, then drop the coefficient fraction (floor).
  assign scaled = (Y_W'(acc) <<< SH) >>> COEF_FRAC;
  assign y_sum  = scaled + Y_W'(d_eff);

  always_comb begin
    if ((&y_sum[Y_W-1:OUT_W-1]) || !(|y_sum[Y_W-1:OUT_W-1])) begin
      y_sat = y_sum[OUT_W-1:0];
    end else if (y_sum[Y_W-1]) begin
      y_sat = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      y_sat = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.in_valid) state_nxt = MAC;
        MAC:     if (k == LAST_K)  state_nxt = ROUND;
        ROUND:   state_nxt = OUT;
        OUT:     if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      k            <= '0;
      ch_cnt       <= '0;
      cur_ch       <= '0;
      lfsr         <= 16'hACE1;
      bus.out_data <= '0;
      bus.out_ch   <= '0;
      bus.coef_ack <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++)
        for (int unsigned t = 0; t < TAPS; t++) hist[c][t] <= '0;
      for (int unsigned t = 0; t < TAPS; t++) coef[t] <= (t == 0) ? COEF_ONE : '0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr_fb};
      bus.coef_ack <= 1'b0;
      if (flush) begin
        acc    <= '0;
        k      <= '0;
        ch_cnt <= '0;
        for (int unsigned c = 0; c < NUM_CH; c++)
          for (int unsigned t = 0; t < TAPS; t++) hist[c][t] <= '0;
      end else begin
        case (state)
          IDLE: begin
            // A same-cycle sample wins; coefficients only change between samples.
            if (bus.in_valid) begin
              for (int unsigned t = TAPS - 1; t > 0; t--) hist[ch_cnt][t] <= hist[ch_cnt][t-1];
              hist[ch_cnt][0] <= sample_in;
              cur_ch <= ch_cnt;
              acc    <= '0;
              k      <= '0;
            end else if (bus.coef_we) begin
              coef[bus.coef_addr] <= bus.coef_data;
              bus.coef_ack        <= 1'b1;
            end
          end
          MAC: begin
            acc <= acc + ACC_W'(prod);
            k   <= k + 1'b1;
          end
          ROUND: begin
            bus.out_data <= y_sat;
            bus.out_ch   <= cur_ch;
          end
          OUT: begin
            if (bus.out_ready) ch_cnt <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_fir_dither.sv
// Scoreboard bench for audio_fir_dither: undithered instance for the filter path,
// a DITHER_W=8 instance checked against an LFSR reference model.
`timescale 1ns/1ps
module tb_audio_fir_dither;
  localparam int IN_W = 8, OUT_W = 24, NUM_CH = 2, TAPS = 4, COEF_W = 16, COEF_FRAC = 14;
  localparam int AW = 2, CW = 1;
`ifdef NOISE_SHAPE_EN
  localparam int BOUND = 256;
`else
  localparam int BOUND = 128;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic flush2 = 1'b0;
  always #5 clk = ~clk;

  audio_fir_dither_if #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W), .AW(AW), .CW(CW)) bus ();
  audio_fir_dither_if #(.IN_W(IN_W), .OUT_W(OUT_W), .COEF_W(COEF_W), .AW(AW), .CW(CW)) bus2 ();

  audio_fir_dither #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .TAPS(TAPS),
                     .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .DITHER_W(0))
    dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

  audio_fir_dither #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_CH(NUM_CH), .TAPS(TAPS),
                     .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .DITHER_W(8))
    dut2 (.clk(clk), .rst_n(rst_n), .flush(flush2), .bus(bus2));

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [CW-1:0]    ch;
    int               acc_cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [15:0] ref_lfsr;
  logic signed [7:0] err_m [NUM_CH];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ref_lfsr <= 16'hACE1;
    else        ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the undithered instance.
  logic prev_v1 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.out_valid && !prev_v1) begin
      if (q1.size() == 0) check("unexpected out_valid", 1, 0);
      else check("latency", 64'(cyc - q1[0].acc_cyc), 64'(TAPS + 2));
    end
    if (bus.out_valid && bus.out_ready && q1.size() > 0) begin
      e = q1.pop_front();
      check("out_data", 64'(bus.out_data), 64'(e.data));
      check("out_ch", 64'(bus.out_ch), 64'(e.ch));
    end
    prev_v1 = bus.out_valid;
  end

  // Monitor for the dithered instance.
  logic prev_v2 = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    int v;
    if (bus2.out_valid && !prev_v2) begin
      if (q2.size() == 0) check("dither unexpected out_valid", 1, 0);
      else check("dither latency", 64'(cyc - q2[0].acc_cyc), 64'(TAPS + 2));
    end
    if (bus2.out_valid && bus2.out_ready && q2.size() > 0) begin
      e = q2.pop_front();
      v = int'($signed(bus2.out_data));
      check("dither out_data", 64'(bus2.out_data), 64'(e.data));
      check("dither out_ch", 64'(bus2.out_ch), 64'(e.ch));
      check("dither bound", 64'((v <= BOUND) && (v >= -BOUND)), 1);
    end
    prev_v2 = bus2.out_valid;
  end

  task automatic send(input logic [7:0] x, input logic [23:0] exp_d, input logic exp_ch,
                      input bit push);
    bit taken = 0;
    @(posedge clk); #1;
    bus.in_data  = x;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin taken = 1; break; end
    end
    if (!taken) check("in_ready timeout", 0, 1);
    else if (push) q1.push_back('{data: exp_d, ch: exp_ch, acc_cyc: cyc});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic coef_write(input logic [AW-1:0] a, input logic [15:0] d, input logic exp_ack);
    @(posedge clk); #1;
    bus.coef_we   = 1'b1;
    bus.coef_addr = a;
    bus.coef_data = d;
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    @(negedge clk);
    check("coef_ack", 64'(bus.coef_ack), 64'(exp_ack));
    @(negedge clk);
    check("coef_ack pulse end", 64'(bus.coef_ack), 0);
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q1.size() == 0 && q2.size() == 0 && !bus.out_valid && !bus2.out_valid) begin
        done = 1; break;
      end
    end
    if (!done) check("drain timeout", 0, 1);
  endtask

  task automatic send_dither(input int idx);
    bit taken = 0;
    logic signed [7:0] d;
    logic signed [8:0] de;
    int ch;
    ch = idx % NUM_CH;
    @(posedge clk); #1;
    bus2.in_data  = 8'h80;
    bus2.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus2.in_ready) begin taken = 1; break; end
    end
    if (!taken) begin
      check("dither in_ready timeout", 0, 1);
    end else begin
      int a = cyc;
      @(posedge clk); #1;
      bus2.in_valid = 1'b0;
      // The dither word is the LFSR value held during the ROUND cycle.
      repeat (TAPS) @(posedge clk);
      #1;
      d = ref_lfsr[7:0];
`ifdef NOISE_SHAPE_EN
      de = {d[7], d} - {err_m[ch][7], err_m[ch]};
      err_m[ch] = d;
`else
      de = {d[7], d};
`endif
      q2.push_back('{data: {{(OUT_W-9){de[8]}}, de}, ch: CW'(ch), acc_cyc: a});
    end
    bus2.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data = '0;   bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
    bus.coef_we = 1'b0; bus.coef_addr = '0;   bus.coef_data = '0;
    bus2.in_data = '0;   bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
    bus2.coef_we = 1'b0; bus2.coef_addr = '0;  bus2.coef_data = '0;
    for (int c = 0; c < NUM_CH; c++) err_m[c] = '0;

    repeat (3) @(negedge clk);
    check("reset out_valid", 64'(bus.out_valid), 0);
    check("reset in_ready", 64'(bus.in_ready), 1);
    check("reset coef_ack", 64'(bus.coef_ack), 0);
    check("reset out_data", 64'(bus.out_data), 0);
    check("reset out_ch", 64'(bus.out_ch), 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Default coefficients pass straight through.
    send(8'hFF, 24'h7F0000, 1'b0, 1);
    send(8'h00, 24'h800000, 1'b1, 1);

    // Write during MAC is dropped; ch1 output proves coef[1] is still 0.
    send(8'hFF, 24'h7F0000, 1'b0, 1);
    coef_write(2'd1, 16'd16384, 1'b0);
    send(8'h80, 24'h000000, 1'b1, 1);
    drain();
    coef_write(2'd1, 16'd16384, 1'b1);
    coef_write(2'd2, 16'd16384, 1'b1);
    coef_write(2'd3, 16'd16384, 1'b1);
    pulse_flush();

    // Moving-sum step response with saturation.
    send(8'hC0, 24'h400000, 1'b0, 1);
    send(8'h80, 24'h000000, 1'b1, 1);
    for (int i = 0; i < 3; i++) begin
      send(8'hC0, 24'h7FFFFF, 1'b0, 1);
      send(8'h80, 24'h000000, 1'b1, 1);
    end
    drain();

    // Back-pressure: output held stable, no input taken.
    bus.out_ready = 1'b0;
    send(8'h00, 24'h400000, 1'b0, 1);
    begin
      bit seen = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus.out_valid) begin seen = 1; break; end
      end
      if (!seen) check("stall out_valid timeout", 0, 1);
    end
    @(posedge clk); #1;
    bus.in_data = 8'hFF; bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall out_valid", 64'(bus.out_valid), 1);
      check("stall out_data", 64'(bus.out_data), 64'h400000);
      check("stall out_ch", 64'(bus.out_ch), 0);
      check("stall in_ready", 64'(bus.in_ready), 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    send(8'h80, 24'h000000, 1'b1, 1);
    drain();

    // Flush mid-MAC on ch1: no output, history and channel counter cleared.
    send(8'h80, 24'h000000, 1'b0, 1);
    send(8'hFF, 24'h000000, 1'b1, 0);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("flush no out_valid", 64'(bus.out_valid), 0);
    end
    send(8'hFF, 24'h7F0000, 1'b0, 1);
    drain();

    // Same abort via rst_n; coefficients return to default.
    send(8'h40, 24'h000000, 1'b1, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("rst in_ready", 64'(bus.in_ready), 1);
    check("rst out_valid", 64'(bus.out_valid), 0);
    check("rst out_data", 64'(bus.out_data), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rst no out_valid", 64'(bus.out_valid), 0);
    end
    send(8'hFF, 24'h7F0000, 1'b0, 1);
    send(8'h00, 24'h800000, 1'b1, 1);
    drain();

    // Silent input on the dithered instance exposes the dither word.
    for (int i = 0; i < 8; i++) send_dither(i);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
